l_transform: RTL and testbench



---
 rtl/l_transform.sv | 133 +++++++++++++
 tb/tb_l_transform.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/l_transform.sv
// Grasshopper linear transform L, computed as ROUNDS iterations of R.
// Ports: clk/rst, data_i/valid_i/ready_o in, data_o/valid_o/ready_i out, busy_o.
module l_transform #(
  parameter int ROUNDS = 16,
  parameter int CNT_W  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [255:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  // l() coefficient for byte a_k, indexed by k
  localparam logic [7:0] LC [0:15] = '{
    8'd1,   8'd148, 8'd32,  8'd133,
    8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194,
    8'd16,  8'd133, 8'd32,  8'd148
  };

  fsm_t             state;
  logic [127:0]     state_reg;
  logic [CNT_W-1:0] cnt;
  logic [127:0]     r_next;
  logic             unused_hi;

  assign unused_hi = ^data_i[255:128];

  // multiply by x modulo x^8+x^7+x^6+x+1
  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'hc3 : 8'h00);
  endfunction

  // constant coefficient c makes this a fixed xor network
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] c
  );
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] l_fn(
    input logic [127:0] a
  );
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 16; k++) begin
      acc = acc ^ gf_mul(a[8*k +: 8], LC[k]);
    end
    return acc;
  endfunction

  assign r_next = {l_fn(state_reg), state_reg[127:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      state_reg <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            state_reg <= data_i[127:0];
            cnt       <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          state_reg <= r_next;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            if (valid_i) begin
              state_reg <= data_i[127:0];
              cnt       <= '0;
              state     <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // outputs decode the state register; rst forces them quiet
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    data_o  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: ready_o = 1'b1;
        BUSY: busy_o  = 1'b1;
        DONE: begin
          ready_o = ready_i;
          valid_o = 1'b1;
          data_o  = {128'b0, state_reg};
        end
        default: ready_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_l_transform.sv
// Directed-vector bench for l_transform.
// Covers R=1 single steps and full L=R^16 with handshakes and reset.
module tb_l_transform;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [255:0] d1_i, d1_o;
  logic         v1_i, r1_i, v1_o, rdy1_o, b1_o;
  logic [255:0] d16_i, d16_o;
  logic         v16_i, r16_i, v16_o, rdy16_o, b16_o;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] A0 = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] A1 = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] A2 = 128'h79d26221b87b584cd42fbc4ffea5de9a;

  l_transform #(.ROUNDS(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst),
    .data_i(d1_i), .valid_i(v1_i), .ready_o(rdy1_o),
    .data_o(d1_o), .valid_o(v1_o), .ready_i(r1_i),
    .busy_o(b1_o)
  );

  l_transform #(.ROUNDS(16), .CNT_W(4)) u16 (
    .clk(clk), .rst(rst),
    .data_i(d16_i), .valid_i(v16_i), .ready_o(rdy16_o),
    .data_o(d16_o), .valid_o(v16_o), .ready_i(r16_i),
    .busy_o(b16_o)
  );

  task automatic check(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run1(
    input string        tag,
    input logic [127:0] din,
    input logic [127:0] exp
  );
    check({tag, "_rdy"}, rdy1_o, 1);
    d1_i = {128'b0, din};
    v1_i = 1'b1;
    step;
    v1_i = 1'b0;
    check({tag, "_busy"}, b1_o, 1);
    step;
    check({tag, "_vld"}, v1_o, 1);
    check({tag, "_data"}, d1_o, {128'b0, exp});
    r1_i = 1'b1;
    step;
    r1_i = 1'b0;
    check({tag, "_idle"}, v1_o, 0);
  endtask

  task automatic wait16(
    input string        tag,
    input logic [127:0] exp
  );
    int n;
    n = 0;
    while (!v16_o && n < 40) begin
      step;
      n++;
    end
    check({tag, "_to"}, v16_o, 1);
    check({tag, "_data"}, d16_o, {128'b0, exp});
  endtask

  initial begin
    int busy_n;
    int early;
    rst   = 1'b1;
    d1_i  = '0; v1_i = 1'b0; r1_i = 1'b0;
    d16_i = '0; v16_i = 1'b0; r16_i = 1'b0;
    step;
    step;
    check("rst_vld", v16_o, 0);
    check("rst_rdy", rdy16_o, 0);
    check("rst_busy", b16_o, 0);
    check("rst_data", d16_o, 0);
    rst = 1'b0;
    step;
    check("post_rst_rdy", rdy16_o, 1);

    run1("r1a", 128'h00000000000000000000000000000100,
         128'h94000000000000000000000000000001);
    run1("r1b", 128'h94000000000000000000000000000001,
         128'ha5940000000000000000000000000000);
    run1("r1c", 128'ha5940000000000000000000000000000,
         128'h64a59400000000000000000000000000);

    // full L with exact latency and busy length
    d16_i = {128'b0, A0};
    v16_i = 1'b1;
    step;
    v16_i = 1'b0;
    busy_n = 0;
    early  = 0;
    for (int i = 0; i < 16; i++) begin
      if (b16_o) busy_n++;
      if (v16_o) early++;
      step;
    end
    check("lat_busy_n", busy_n, 16);
    check("lat_early", early, 0);
    check("lat_vld", v16_o, 1);
    check("lat_busy_end", b16_o, 0);
    check("lat_data", d16_o, {128'b0, A1});
    check("lat_upper", d16_o[255:128], 0);
    r16_i = 1'b1;
    step;
    r16_i = 1'b0;

    d16_i = '0;
    v16_i = 1'b1;
    step;
    v16_i = 1'b0;
    wait16("zero", 128'h0);
    r16_i = 1'b1;
    step;
    r16_i = 1'b0;

    // garbage upper half, junk valid pulses while busy
    d16_i = {128'hdeadbeef_cafef00d_01234567_89abcdef, A0};
    v16_i = 1'b1;
    step;
    for (int i = 0; i < 16; i++) begin
      if (i >= 3 && i <= 5) begin
        v16_i = 1'b1;
        d16_i = {128'h0, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
      end else begin
        v16_i = 1'b0;
      end
      step;
    end
    v16_i = 1'b0;
    check("bp_vld", v16_o, 1);
    check("bp_data", d16_o, {128'b0, A1});
    for (int i = 0; i < 5; i++) begin
      step;
      check("hold_vld", v16_o, 1);
      check("hold_data", d16_o, {128'b0, A1});
    end

    // release with a new block on the same edge
    d16_i = {128'b0, A1};
    v16_i = 1'b1;
    r16_i = 1'b1;
    #1;
    check("rel_rdy", rdy16_o, 1);
    step;
    v16_i = 1'b0;
    r16_i = 1'b0;
    check("rel_busy", b16_o, 1);
    check("rel_vld", v16_o, 0);
    wait16("chain", A2);
    r16_i = 1'b1;
    step;
    r16_i = 1'b0;

    // reset in the middle of a block
    d16_i = {128'b0, A1};
    v16_i = 1'b1;
    step;
    v16_i = 1'b0;
    repeat (7) step;
    check("mid_busy", b16_o, 1);
    rst = 1'b1;
    step;
    check("mid_rst_vld", v16_o, 0);
    check("mid_rst_busy", b16_o, 0);
    check("mid_rst_data", d16_o, 0);
    rst = 1'b0;
    step;
    check("mid_rdy", rdy16_o, 1);
    d16_i = {128'b0, A0};
    v16_i = 1'b1;
    step;
    v16_i = 1'b0;
    wait16("fresh", A1);
    r16_i = 1'b1;
    step;
    r16_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
